hazard_ctrl_unit: RTL and testbench

//  Parametrised pipeline hazard/stall controller for the RV32 core; successor to the fixed 5-stage detector.

---
 rtl/hazard_ctrl_if.sv | 28 ++
 rtl/hazard_ctrl_unit.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: hazard sources and counter clear in, stall/flush vectors,
// FSM state and perf counters out. Producers use master, the controller uses slave.
interface hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
);
  logic                  load_hazard_i;
  logic                  m_type_stall_i;
  logic                  mem_wait_i;
  logic                  branch_redirect_i;
  logic                  trap_i;
  logic                  cnt_clr_i;
  logic [NUM_STAGES-1:0] stall_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic [1:0]            state_o;
  logic [CNT_W-1:0]      stall_cycles_o;
  logic [CNT_W-1:0]      flush_events_o;

  modport master (
    output load_hazard_i, m_type_stall_i, mem_wait_i, branch_redirect_i, trap_i, cnt_clr_i,
    input  stall_o, flush_o, state_o, stall_cycles_o, flush_events_o
  );

  modport slave (
    input  load_hazard_i, m_type_stall_i, mem_wait_i, branch_redirect_i, trap_i, cnt_clr_i,
    output stall_o, flush_o, state_o, stall_cycles_o, flush_events_o
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/stall controller. Picks one stall/flush pattern per cycle from the
// highest-priority active source, sequences multi-cycle load-use bubbles and trap
// drains in a small FSM, and keeps saturating stall/flush perf counters.
module hazard_ctrl_unit #(
  parameter int NUM_STAGES = 5,
  parameter int ID_IDX     = 2,
  parameter int EX_IDX     = 3,
  parameter int LU_BUBBLES = 1,
  parameter int TRAP_DRAIN = 1,
  parameter int CNT_W      = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LU    = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    P_NONE, P_TRAP, P_MWAIT, P_MTYPE, P_REDIR, P_LU
  } pat_e;

  localparam logic [2:0] LU_RELOAD = 3'(LU_BUBBLES - 1);
  localparam logic [2:0] TD_RELOAD = 3'(TRAP_DRAIN - 1);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  pat_e                  pat;
  logic [NUM_STAGES-1:0] stall, flush;

  // Priority select of the single pattern driven this cycle (none during reset)
  always_comb begin
    pat = P_NONE;
    if (rst_i)                                  pat = P_NONE;
    else if (bus.trap_i || state_q == S_DRAIN)  pat = P_TRAP;
    else if (bus.mem_wait_i)                    pat = P_MWAIT;
    else if (bus.m_type_stall_i)                pat = P_MTYPE;
    else if (bus.branch_redirect_i)             pat = P_REDIR;
    else if (bus.load_hazard_i || state_q == S_LU) pat = P_LU;
  end

  // Expand the selected pattern into per-register stall/flush bits
  always_comb begin
    stall = '0;
    flush = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      case (pat)
        P_TRAP:  flush[k] = (k >= 1) && (k <= EX_IDX);
        P_MWAIT: begin
          stall[k] = (k <= EX_IDX);
          flush[k] = (k == EX_IDX + 1);
        end
        P_MTYPE: begin
          stall[k] = (k <= ID_IDX);
          flush[k] = (k == EX_IDX);
        end
        P_REDIR: flush[k] = (k >= 1) && (k <= ID_IDX);
        P_LU: begin
          stall[k] = (k < ID_IDX);
          flush[k] = (k == ID_IDX);
        end
        default: ;
      endcase
    end
  end

  // Next state / remaining-count for load-use bubbles and trap drain
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (pat == P_TRAP) begin
          if (TRAP_DRAIN > 1) begin
            state_d = S_DRAIN;
            cnt_d   = TD_RELOAD;
          end
        end else if (pat == P_LU && LU_BUBBLES > 1) begin
          state_d = S_LU;
          cnt_d   = LU_RELOAD;
        end
      end
      S_LU: begin
        if (bus.trap_i) begin
          // Abort the bubble sequence; the trap cycle itself is drain cycle 1
          state_d = (TRAP_DRAIN > 1) ? S_DRAIN : S_RUN;
          cnt_d   = (TRAP_DRAIN > 1) ? TD_RELOAD : 3'd0;
        end else if (bus.mem_wait_i || bus.m_type_stall_i) begin
          // Higher source owns the pipe; bubble count is frozen
        end else if (bus.branch_redirect_i) begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd1) begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DRAIN: begin
        if (bus.trap_i) begin
          state_d = (TRAP_DRAIN > 1) ? S_DRAIN : S_RUN;
          cnt_d   = (TRAP_DRAIN > 1) ? TD_RELOAD : 3'd0;
        end else if (cnt_q == 3'd1) begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Saturating perf counters; clear beats a same-cycle increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall[0] && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + 1'b1;
      if ((bus.trap_i || pat == P_REDIR) && !(&flush_cnt_q))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State and counter registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.flush_o        = flush;
  assign bus.state_o        = state_q;
  assign bus.stall_cycles_o = stall_cnt_q;
  assign bus.flush_events_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: a driver applies directed then random hazard
// inputs and pushes the reference model's expected outputs; a negedge monitor pops
// and compares. Built with LU_BUBBLES=3, TRAP_DRAIN=2, CNT_W=4 so multi-cycle
// sequences and counter saturation are reachable quickly.
module tb_hazard_ctrl_unit;
  localparam int NS  = 5;
  localparam int ID  = 2;
  localparam int EX  = 3;
  localparam int LUB = 3;
  localparam int TD  = 2;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [NS-1:0] st;
    logic [NS-1:0] fl;
    logic [1:0]    state;
    logic [CW-1:0] sc;
    logic [CW-1:0] fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  hazard_ctrl_unit #(
    .NUM_STAGES(NS), .ID_IDX(ID), .EX_IDX(EX),
    .LU_BUBBLES(LUB), .TRAP_DRAIN(TD), .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: bubbles / drain cycles still owed, plus event counts
  int drain_left = 0;
  int lu_left    = 0;
  int m_sc       = 0;
  int m_fe       = 0;

  task automatic model_step(input bit lh, mt, mw, br, tr, clr, rs, output exp_t e);
    int st, fl, stv;
    bit accepted;
    st = 0; fl = 0; accepted = 0;
    stv = (drain_left > 0) ? 2 : (lu_left > 0) ? 1 : 0;
    e.state = 2'(stv);
    e.sc    = CW'(m_sc);
    e.fe    = CW'(m_fe);
    if (rs) begin
      drain_left = 0; lu_left = 0; m_sc = 0; m_fe = 0;
    end else begin
      if (tr || drain_left > 0) begin
        fl = ((1 << (EX + 1)) - 1) & ~1;
        drain_left = tr ? TD - 1 : drain_left - 1;
        lu_left = 0;
      end else if (mw) begin
        st = (1 << (EX + 1)) - 1;
        fl = 1 << (EX + 1);
      end else if (mt) begin
        st = (1 << (ID + 1)) - 1;
        fl = 1 << EX;
      end else if (br) begin
        fl = ((1 << (ID + 1)) - 1) & ~1;
        lu_left = 0;
        accepted = 1;
      end else if (lh || lu_left > 0) begin
        st = (1 << ID) - 1;
        fl = 1 << ID;
        lu_left = (lu_left > 0) ? lu_left - 1 : LUB - 1;
      end
      if (clr) begin
        m_sc = 0; m_fe = 0;
      end else begin
        if ((st & 1) != 0 && m_sc < CMAX) m_sc++;
        if ((tr || accepted) && m_fe < CMAX) m_fe++;
      end
    end
    e.st = NS'(st);
    e.fl = NS'(fl);
  endtask

  // One clock of stimulus: drive after the edge, queue the expectation
  task automatic cyc(input bit lh, mt, mw, br, tr, clr, rs);
    exp_t e;
    @(posedge clk);
    #1;
    bus.load_hazard_i     = lh;
    bus.m_type_stall_i    = mt;
    bus.mem_wait_i        = mw;
    bus.branch_redirect_i = br;
    bus.trap_i            = tr;
    bus.cnt_clr_i         = clr;
    rst                   = rs;
    model_step(lh, mt, mw, br, tr, clr, rs, e);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
  endtask

  // Monitor: outputs are always presented, so compare every cycle with an expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall_o",        int'(bus.stall_o),        int'(e.st));
      chk("flush_o",        int'(bus.flush_o),        int'(e.fl));
      chk("state_o",        int'(bus.state_o),        int'(e.state));
      chk("stall_cycles_o", int'(bus.stall_cycles_o), int'(e.sc));
      chk("flush_events_o", int'(bus.flush_events_o), int'(e.fe));
    end
  end

  initial begin
    bus.load_hazard_i = 0; bus.m_type_stall_i = 0; bus.mem_wait_i = 0;
    bus.branch_redirect_i = 0; bus.trap_i = 0; bus.cnt_clr_i = 0;
    repeat (2) @(posedge clk);
    //     lh mt mw br tr clr rs
    cyc(0, 0, 0, 0, 0, 0, 1);                 // reset state
    cyc(0, 0, 0, 0, 0, 0, 0);
    // load-use, 3 bubbles then back to RUN
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    // load-use interrupted by mem wait in bubble 2
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    // m_type 4 cycles, redirect masked in cycle 2
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // trap during LU with mem wait: 2-cycle drain
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    // redirect beats load hazard
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // saturation, clear-with-stall, reset inside LU
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (20) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12,
          $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 2);
    end
    // let the monitor drain the scoreboard, bounded
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
